pwm_multi: RTL and testbench

//  Multi-channel PWM generator sharing one period counter. Adds a clock prescaler,
//  a programmable period, edge- or centre-aligned mode, and glitch-free duty/period

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_prescaler.sv | 35 +++
 rtl/pwm_multi.sv | 135 +++++++++++++
 tb/tb_pwm_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: alignment mode and centre-mode count direction.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: tick once every prescale+1 cycles while enabled.
module pwm_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  // >= rather than == so a live shrink of prescale below pre_cnt wraps at once
  assign tick = enable && (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!enable || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/centre-aligned period counter, shadowed
// period/duty/mode loaded only at a period boundary, registered compare outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      center_mode,
  input  logic                      update,
  output logic                      update_ack,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic tick;
  logic boundary;
  logic load;

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  dir_e                            dir_q, dir_d;
  logic [WIDTH-1:0]                p_s_q, p_s_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  d_s_q, d_s_d;
  mode_e                           mode_s_q, mode_s_d;
  logic                            pending_q, pending_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            ack_q, ps_q;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  // Boundary = last tick of the period; the counter returns to 0 on it.
  // Centre mode with P==1 turns at the top, so that peak is also the boundary.
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (mode_s_q == MODE_EDGE) begin
        boundary = (cnt_q == p_s_q);
      end else if (p_s_q == '0) begin
        boundary = 1'b1;
      end else if (dir_q == DIR_DOWN) begin
        boundary = (cnt_q == WIDTH'(1));
      end else begin
        boundary = (p_s_q == WIDTH'(1)) && (cnt_q == WIDTH'(1));
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable || boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (mode_s_q == MODE_EDGE) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == p_s_q) begin
          dir_d = DIR_DOWN;
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // A request arriving on the boundary cycle itself loads on that boundary.
  assign load = (pending_q || update) && (boundary || !enable);

  always_comb begin
    p_s_d     = p_s_q;
    d_s_d     = d_s_q;
    mode_s_d  = mode_s_q;
    pending_d = pending_q;
    if (load) begin
      p_s_d     = period;
      d_s_d     = duty;  // packed element i is duty[i*WIDTH +: WIDTH]
      mode_s_d  = mode_e'(center_mode);
      pending_d = 1'b0;
    end else if (update) begin
      pending_d = 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign pwm_d[i] = enable && (cnt_q < d_s_q[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      p_s_q     <= '0;
      d_s_q     <= '0;
      mode_s_q  <= MODE_EDGE;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      ack_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      p_s_q     <= p_s_d;
      d_s_q     <= d_s_d;
      mode_s_q  <= mode_s_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      ack_q     <= load;
      ps_q      <= boundary;
    end
  end

  assign pwm_out      = pwm_q;
  assign update_ack   = ack_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: per-cycle expectations for channel 1, period_start
// and update_ack held in a queue, plus high-time counts over whole periods.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [PW-1:0]   prescale;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic            center_mode;
  logic            update;
  logic            update_ack;
  logic            period_start;
  logic [CH-1:0]   pwm_out;

  int checks = 0;
  int errors = 0;
  int hi_cnt[CH];
  int ps_cnt;
  int ack_cnt;
  logic [2:0] exp_q[$];  // {update_ack, period_start, pwm_out[1]} per cycle

  pwm_multi #(
    .WIDTH      (W),
    .CHANNELS   (CH),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .prescale     (prescale),
    .period       (period),
    .duty         (duty),
    .center_mode  (center_mode),
    .update       (update),
    .update_ack   (update_ack),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input logic [W-1:0] d3, input logic [W-1:0] d2,
                          input logic [W-1:0] d1, input logic [W-1:0] d0);
    duty = {d3, d2, d1, d0};
  endtask

  task automatic push_exp(input logic ack, input logic ps, input logic ch1);
    exp_q.push_back({ack, ps, ch1});
  endtask

  task automatic pop_check(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ch1"}, 32'(pwm_out[1]), 32'(e[0]));
      check({tag, "_ps"},  32'(period_start), 32'(e[1]));
      check({tag, "_ack"}, 32'(update_ack), 32'(e[2]));
    end
  endtask

  task automatic do_update();
    int n;
    update = 1'b1;
    step();
    update = 1'b0;
    n = 1;
    while (!update_ack && n < 100) begin
      step();
      n++;
    end
    check("update_ack_seen", 32'(update_ack), 32'd1);
  endtask

  // Steps until the next period_start pulse; returns cycles taken.
  task automatic gap(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 100);
    check("period_start_seen", 32'(period_start), 32'd1);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    ps_cnt  = 0;
    ack_cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < CH; c++) hi_cnt[c] += int'(pwm_out[c]);
      ps_cnt  += int'(period_start);
      ack_cnt += int'(update_ack);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; enable = 1'b1; prescale = '0; period = 8'd9;
    center_mode = 1'b0; update = 1'b1;
    set_duty(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // 1: reset dominates update/enable
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_pwm", 32'(pwm_out), 32'd0);
      check("reset_ack", 32'(update_ack), 32'd0);
      check("reset_ps", 32'(period_start), 32'd0);
      check("reset_period_shadow", 32'(dut.p_s_q), 32'd0);
      check("reset_duty_shadow", 32'(dut.d_s_q != '0), 32'd0);
    end
    update = 1'b0;
    reset  = 1'b0;
    step();

    // 2: edge, P=9, D={255,10,3,0}
    set_duty(8'd255, 8'd10, 8'd3, 8'd0);
    do_update();
    gap(n);
    for (int k = 1; k <= 10; k++) push_exp(1'b0, k == 10, k <= 3);
    for (int k = 1; k <= 10; k++) begin
      step();
      pop_check("edge_p9");
    end
    measure(10);
    check("edge_ch0_high", hi_cnt[0], 0);
    check("edge_ch1_high", hi_cnt[1], 3);
    check("edge_ch2_high", hi_cnt[2], 10);
    check("edge_ch3_high", hi_cnt[3], 10);
    check("edge_ps_count", ps_cnt, 1);
    gap(n);
    check("edge_period", n, 10);

    // 3: centre, P=4, prescale=1: counter 0..4..1 = 8 ticks = 16 clk;
    // D=2 is high on cnt 1,0,1 (6 clk), D=4 on cnt 3..1,0..3 (14 clk)
    prescale = 8'd1; period = 8'd4; center_mode = 1'b1;
    set_duty(8'd5, 8'd4, 8'd2, 8'd0);
    do_update();
    gap(n);
    gap(n);
    check("centre_period", n, 16);
    measure(16);
    check("centre_ch0_high", hi_cnt[0], 0);
    check("centre_ch1_high", hi_cnt[1], 6);
    check("centre_ch2_high", hi_cnt[2], 14);
    check("centre_ch3_high", hi_cnt[3], 16);
    check("centre_ps_count", ps_cnt, 1);

    // 4: mid-period update D1 3->7, old duty until the boundary
    prescale = '0; period = 8'd9; center_mode = 1'b0;
    set_duty(8'd255, 8'd10, 8'd3, 8'd0);
    do_update();
    gap(n);
    for (int k = 1; k <= 20; k++)
      push_exp(k == 10, (k == 10) || (k == 20), (k <= 3) || (k >= 11 && k <= 17));
    for (int k = 1; k <= 20; k++) begin
      step();
      pop_check("midupd");
      if (k == 4) begin
        set_duty(8'd255, 8'd10, 8'd7, 8'd0);
        update = 1'b1;
      end
      if (k == 5) update = 1'b0;
    end

    // 5: update on the boundary cycle loads there; a second request while
    // pending adds nothing, but duty is sampled at the load cycle (6, not 2)
    for (int k = 1; k <= 30; k++)
      push_exp((k == 10) || (k == 20), (k == 10) || (k == 20) || (k == 30),
               (k <= 7) || (k >= 11 && k <= 15) || (k >= 21 && k <= 26));
    for (int k = 1; k <= 30; k++) begin
      step();
      pop_check("coinc");
      if (k == 9)  begin set_duty(8'd255, 8'd10, 8'd5, 8'd0); update = 1'b1; end
      if (k == 10) update = 1'b0;
      if (k == 12) begin set_duty(8'd255, 8'd10, 8'd2, 8'd0); update = 1'b1; end
      if (k == 13) update = 1'b0;
      if (k == 15) begin set_duty(8'd255, 8'd10, 8'd6, 8'd0); update = 1'b1; end
      if (k == 16) update = 1'b0;
    end

    // 6: disable mid-period with an update: outputs low, immediate load, restart at 0
    for (int k = 1; k <= 20; k++)
      push_exp(k == 4, k == 16, (k <= 3) || (k >= 7 && k <= 10) || (k >= 17));
    for (int k = 1; k <= 20; k++) begin
      step();
      pop_check("disable");
      if (k >= 4 && k <= 6) check("disable_all_low", 32'(pwm_out), 32'd0);
      if (k == 3) begin
        enable = 1'b0;
        set_duty(8'd255, 8'd10, 8'd4, 8'd0);
        update = 1'b1;
      end
      if (k == 4) update = 1'b0;
      if (k == 6) enable = 1'b1;
    end

    // 7: reset mid-operation discards a pending request
    update = 1'b1;
    step();
    update = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    check("midreset_pwm", 32'(pwm_out), 32'd0);
    measure(20);
    check("midreset_ack_count", ack_cnt, 0);
    check("midreset_ch2_high", hi_cnt[2], 0);
    check("midreset_ps_count", ps_cnt, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
